// File: rtl/dm_port_arbiter_if.sv
// dm_port_arbiter_if: p0/p1 requester handshakes (req/op/addr/wdata in, gnt/rvalid/rdata out) and the dm_* data-memory bus
interface dm_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic [1:0]        p0_op;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;
  logic              p1_req;
  logic [1:0]        p1_op;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;
  logic              dm_memRead;
  logic              dm_memWrite;
  logic [ADDR_W-1:0] dm_address;
  logic [DATA_W-1:0] dm_writeData;
  logic [DATA_W-1:0] dm_memOut;
  modport master (
    output p0_req, p0_op, p0_addr, p0_wdata, p1_req, p1_op, p1_addr, p1_wdata, dm_memOut,
    input  p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata,
    input  dm_memRead, dm_memWrite, dm_address, dm_writeData
  );
  modport slave (
    input  p0_req, p0_op, p0_addr, p0_wdata, p1_req, p1_op, p1_addr, p1_wdata, dm_memOut,
    output p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata,
    output dm_memRead, dm_memWrite, dm_address, dm_writeData
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: two-port read/write/swap sequencer for the data memory; clk, reset (async active-low), bus (requester ports + dm_* memory bus)
module dm_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic reset,
  dm_port_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, WR, SWAP_R, SWAP_W} state_t;
  state_t state, nextState;
  logic owner, nextOwner, lastGntValid, lastGntPort, elig0, elig1;
  logic [1:0] winOp;
  logic [ADDR_W-1:0] ownAddr;
  logic [DATA_W-1:0] ownWdata;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      owner <= 1'b0;
    end else begin
      state <= nextState;
      owner <= nextOwner;
    end
  always_comb begin
    lastGntValid = state inside {RD, WR, SWAP_W};
    lastGntPort = owner;
    elig0 = bus.p0_req && !(lastGntValid && !lastGntPort);
    elig1 = bus.p1_req && !(lastGntValid && lastGntPort);
    winOp = elig0 ? bus.p0_op : bus.p1_op;
    nextOwner = state == SWAP_R ? owner : (elig0 || elig1) ? !elig0 : owner;
    nextState = state == SWAP_R ? SWAP_W :
                !(elig0 || elig1) ? IDLE :
                winOp == 2'b01 ? WR :
                winOp == 2'b10 ? SWAP_R : RD;
  end
  always_comb begin
    ownAddr = owner ? bus.p1_addr : bus.p0_addr;
    ownWdata = owner ? bus.p1_wdata : bus.p0_wdata;
    bus.dm_memRead = state inside {RD, SWAP_R};
    bus.dm_memWrite = state inside {WR, SWAP_W};
    bus.dm_address = state == IDLE ? '0 : ownAddr;
    bus.dm_writeData = state inside {WR, SWAP_W} ? ownWdata : '0;
    bus.p0_gnt = lastGntValid && !owner;
    bus.p1_gnt = lastGntValid && owner;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.p0_rvalid <= 1'b0;
      bus.p1_rvalid <= 1'b0;
      bus.p0_rdata <= '0;
      bus.p1_rdata <= '0;
    end else begin
      bus.p0_rvalid <= state inside {RD, SWAP_W} && !owner;
      bus.p1_rvalid <= state inside {RD, SWAP_W} && owner;
      if (state inside {RD, SWAP_R} && !owner) bus.p0_rdata <= bus.dm_memOut;
      if (state inside {RD, SWAP_R} && owner) bus.p1_rdata <= bus.dm_memOut;
    end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: directed and random checks of dm_port_arbiter against a transaction-level memory model
module tb_dm_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  typedef struct packed {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  dm_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  dm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic [DW-1:0] mem [32] = '{default: '0};
  logic [DW-1:0] gm [32] = '{default: '0};
  assign bus.dm_memOut = mem[bus.dm_address];
  always @(negedge clk) if (bus.dm_memWrite) mem[bus.dm_address] <= bus.dm_writeData;
  logic [1:0] req = '0;
  logic [1:0] op [2] = '{default: '0};
  logic [AW-1:0] addr [2] = '{default: '0};
  logic [DW-1:0] wdata [2] = '{default: '0};
  assign bus.p0_req = req[0];
  assign bus.p0_op = op[0];
  assign bus.p0_addr = addr[0];
  assign bus.p0_wdata = wdata[0];
  assign bus.p1_req = req[1];
  assign bus.p1_op = op[1];
  assign bus.p1_addr = addr[1];
  assign bus.p1_wdata = wdata[1];
  logic [1:0] gnt, rv;
  logic [DW-1:0] rd [2];
  assign gnt = {bus.p1_gnt, bus.p0_gnt};
  assign rv = {bus.p1_rvalid, bus.p0_rvalid};
  assign rd[0] = bus.p0_rdata;
  assign rd[1] = bus.p1_rdata;
  txn_t tq [2][64];
  int hd [2];
  int tl [2];
  int glog [2][16];
  int gn [2];
  int rvCyc [2];
  logic [1:0] expRv = '0;
  logic [1:0] prevG = '0;
  logic [DW-1:0] expRd [2];
  logic [DW-1:0] rdLast [2];
  int cyc, base, checks, failures;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask
  task automatic push(input int p, input logic [1:0] o, input logic [AW-1:0] a, input logic [DW-1:0] d);
    tq[p][tl[p] % 64] = '{op: o, addr: a, wdata: d};
    tl[p]++;
  endtask
  task automatic drive();
    for (int p = 0; p < 2; p++) begin
      req[p] = hd[p] != tl[p];
      if (hd[p] != tl[p]) begin
        op[p] = tq[p][hd[p] % 64].op;
        addr[p] = tq[p][hd[p] % 64].addr;
        wdata[p] = tq[p][hd[p] % 64].wdata;
      end
    end
  endtask
  task automatic tick();
    txn_t t;
    @(negedge clk);
    cyc++;
    chk("one_gnt_per_cycle", 32'(gnt[0] & gnt[1]), 32'd0);
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rvalid%0d", p), 32'(rv[p]), 32'(expRv[p]));
      if (rv[p]) begin
        rdLast[p] = rd[p];
        rvCyc[p] = cyc;
      end
      if (expRv[p]) chk($sformatf("rdata%0d", p), rd[p], expRd[p]);
      expRv[p] = 1'b0;
      if (gnt[p]) begin
        chk($sformatf("no_b2b_gnt%0d", p), 32'(prevG[p]), 32'd0);
        chk($sformatf("gnt_has_req%0d", p), 32'(hd[p] != tl[p]), 32'd1);
        if (hd[p] != tl[p]) begin
          t = tq[p][hd[p] % 64];
          chk($sformatf("gnt_addr%0d", p), 32'(bus.dm_address), 32'(t.addr));
          chk($sformatf("gnt_memRead%0d", p), 32'(bus.dm_memRead), 32'(t.op == 2'b00 || t.op == 2'b11));
          chk($sformatf("gnt_memWrite%0d", p), 32'(bus.dm_memWrite), 32'(t.op == 2'b01 || t.op == 2'b10));
          if (t.op == 2'b01 || t.op == 2'b10) chk($sformatf("gnt_wdata%0d", p), bus.dm_writeData, t.wdata);
          if (t.op != 2'b01) begin
            expRv[p] = 1'b1;
            expRd[p] = gm[t.addr];
          end
          if (t.op == 2'b01 || t.op == 2'b10) gm[t.addr] = t.wdata;
          glog[p][gn[p] % 16] = cyc;
          gn[p]++;
          hd[p]++;
        end
      end
      prevG[p] = gnt[p];
    end
    @(posedge clk);
    #1;
    drive();
  endtask
  task automatic run(input int budget);
    int n = 0;
    while ((hd[0] != tl[0] || hd[1] != tl[1] || expRv != 2'b00) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_within_budget", 32'((tl[0] - hd[0]) + (tl[1] - hd[1]) + int'(expRv != 2'b00)), 32'd0);
  endtask
  task automatic startTest();
    gn[0] = 0;
    gn[1] = 0;
    drive();
    base = cyc + 1;
  endtask
  initial begin
    push(0, 2'b00, 5'd0, '0);
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rv), 32'd0);
    chk("rst_rdata0", rd[0], 32'd0);
    chk("rst_rdata1", rd[1], 32'd0);
    chk("rst_dm_ctrl", 32'({bus.dm_memRead, bus.dm_memWrite, bus.dm_address}), 32'd0);
    chk("rst_dm_wdata", bus.dm_writeData, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    startTest();
    run(20);
    chk("rst_release_gnt_lat", 32'(glog[0][0] - base), 32'd1);
    chk("rst_release_rvalid_lat", 32'(rvCyc[0] - base), 32'd2);
    push(0, 2'b01, 5'd3, 32'h12345678);
    push(0, 2'b00, 5'd3, '0);
    startTest();
    run(20);
    chk("wr_gnt_lat", 32'(glog[0][0] - base), 32'd1);
    chk("rd_after_wr_gnt", 32'(glog[0][1] - base), 32'd3);
    chk("rd_rvalid_after_gnt", 32'(rvCyc[0] - glog[0][1]), 32'd1);
    chk("rd_back_data", rdLast[0], 32'h12345678);
    push(0, 2'b00, 5'd3, '0);
    push(1, 2'b00, 5'd9, '0);
    push(0, 2'b11, 5'd3, '0);
    startTest();
    run(20);
    chk("cont_p0_first", 32'(glog[0][0] - base), 32'd1);
    chk("cont_p1_second", 32'(glog[1][0] - base), 32'd2);
    chk("cont_p0_third", 32'(glog[0][1] - base), 32'd3);
    push(1, 2'b01, 5'd30, 32'h00000001);
    startTest();
    run(20);
    push(1, 2'b10, 5'd30, 32'hAAAA5555);
    startTest();
    tick();
    tick();
    push(0, 2'b00, 5'd30, '0);
    drive();
    run(20);
    chk("swap_gnt_lat", 32'(glog[1][0] - base), 32'd2);
    chk("swap_rvalid_lat", 32'(rvCyc[1] - base), 32'd3);
    chk("swap_then_p0_gnt", 32'(glog[0][0] - base), 32'd3);
    chk("swap_old_data", rdLast[1], 32'h00000001);
    chk("swap_new_data", rdLast[0], 32'hAAAA5555);
    for (int i = 0; i < 4; i++) push(0, 2'b01, 5'(10 + i), $urandom);
    startTest();
    run(30);
    for (int i = 0; i < 3; i++) chk($sformatf("b2b_spacing%0d", i), 32'(glog[0][i + 1] - glog[0][i]), 32'd2);
    push(0, 2'b01, 5'd7, 32'h0BADF00D);
    startTest();
    run(20);
    push(1, 2'b10, 5'd7, 32'hDEADBEEF);
    startTest();
    tick();
    @(negedge clk);
    chk("swapR_memRead", 32'(bus.dm_memRead), 32'd1);
    chk("swapR_no_gnt", 32'(gnt), 32'd0);
    #1;
    reset = 1'b0;
    #1;
    chk("midswap_rst_dm_ctrl", 32'({bus.dm_memRead, bus.dm_memWrite}), 32'd0);
    chk("midswap_rst_gnt", 32'(gnt), 32'd0);
    chk("midswap_rst_rvalid", 32'(rv), 32'd0);
    hd[1] = tl[1];
    drive();
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("midswap_no_write", 32'(bus.dm_memWrite), 32'd0);
    chk("midswap_mem_kept", mem[7], 32'h0BADF00D);
    chk("midswap_no_gnt_rv", 32'({gnt, rv}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    prevG = '0;
    expRv = '0;
    push(1, 2'b00, 5'd7, '0);
    startTest();
    run(20);
    chk("midswap_reread", rdLast[1], 32'h0BADF00D);
    for (int it = 0; it < 30; it++) begin
      for (int p = 0; p < 2; p++)
        repeat ($urandom_range(0, 3)) push(p, 2'($urandom_range(0, 3)), 5'($urandom), $urandom);
      drive();
      run(60);
    end
    for (int i = 0; i < 32; i++) chk($sformatf("mem_final%0d", i), mem[i], gm[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
